mna_flit_boxer: RTL and testbench
=================================

MNA_FLIT_BOXER -- requirements
Module: mna_flit_boxer

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst; polarity and synchronicity are fixed.
REQ-002 Ports SHALL be:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- rvalid  input  1  AXI4-Lite read response valid.
- rdata  input  32  read data.
- rresp  input  2  read response code.
- rready  output  1  read response accepted.
- bvalid  input  1  AXI4-Lite write response valid.
- bresp  input  2  write response code.
- bready  output  1  write response accepted.
- noc_data  output  37  flit toward NoC.
- noc_valid  output  1  flit valid.
- noc_ready  input  1  NoC accepts flit.
REQ-003 Flit format SHALL be:
- [36:35] type: 2'b10 header, 2'b01 payload, 2'b00 idle.
- Header: [0] read flag (1 = read, 0 = write); [2:1] resp code; [34:3] zero.
- Payload: [31:0] rdata; [34:32] zero.

Function
REQ-004 The FSM SHALL have three states:
- IDLE: accepting a response.
- HDR: presenting the header flit.
- DATA: presenting the payload flit.
REQ-005 In IDLE, rready/bready SHALL be driven combinationally high only for the granted valid source, and only if rst is low; both SHALL be 0 outside IDLE.
REQ-006 On a handshake in IDLE, the block SHALL register the read flag, resp, and rdata (reads only) and move to HDR on the next edge.
REQ-007 Header flit SHALL be presented with noc_valid=1 in the cycle after acceptance (latency 1).
REQ-008 HDR on noc_ready=1: read goes to DATA, write goes to IDLE; noc_ready=0 holds HDR.
REQ-009 DATA on noc_ready=1 SHALL go to IDLE; noc_ready=0 holds DATA.
REQ-010 While noc_valid=1 and noc_ready=0, noc_data SHALL remain bit-stable.
REQ-011 In IDLE, noc_valid=0 and noc_data=37'b0.
REQ-012 Responses arriving while not in IDLE SHALL stall (ready low) and SHALL NOT be lost or overwrite held data.
REQ-013 A write transaction SHALL emit exactly one flit; a read transaction SHALL emit exactly two, header then payload, never interleaved with another transaction.
REQ-014 Peak throughput: read 3 cycles per transaction, write 2 cycles per transaction, with noc_ready held high.

Reset
REQ-015 Asserting rst SHALL force, immediately and asynchronously:
- state IDLE
- noc_valid=0, noc_data=0
- rready=0, bready=0
- holding registers and arbitration flag cleared to 0
REQ-016 Reset mid-transaction SHALL abandon the in-flight flit(s) without emitting a partial sequence after release.

Configuration
REQ-017 With MNA_BOXER_RR_ARB_EN defined:
- Simultaneous rvalid and bvalid in IDLE SHALL be granted round-robin via a last-grant flag.
- The flag toggles to the granted source on each accept.
- The flag resets to "last = write", so read wins first.
REQ-018 Without MNA_BOXER_RR_ARB_EN, read SHALL always have fixed priority over write and no last-grant flag SHALL exist.

Verification
REQ-019 Read response: rdata=32'hDEADBEEF, rresp=0, noc_ready=1 -> header 37'h10_0000_0001, then payload 37'h08_DEADBEEF, then idle; rready high 1 cycle.
REQ-020 Write response: bresp=2'b10, noc_ready=1 -> single header 37'h10_0000_0004; bready high 1 cycle; no payload flit.
REQ-021 Backpressure: read with noc_ready=0 for 5 cycles in HDR and 3 in DATA -> noc_data stable throughout, flits delivered in order after release.
REQ-022 Simultaneous rvalid and bvalid held 4 transactions:
- RR build: grant order read, write, read, write.
- Fixed build: all reads first.
REQ-023 rst asserted while in DATA with noc_ready=0 -> noc_valid drops the same cycle, state IDLE, no payload emitted after release.
REQ-024 New rvalid during HDR -> rready stays 0 until return to IDLE; new data accepted intact afterward.

Source files
------------

// File: rtl/mna_flit_boxer.sv
// Purpose: boxes AXI4-Lite read/write responses into 37-bit NoC flits (header, plus payload for reads).
// Latency: header flit valid one cycle after the response handshake; read payload follows the header.
// Backpressure: noc_ready low holds the current flit bit-stable; rready/bready stay low until back in IDLE.
// Optional: define MNA_BOXER_RR_ARB_EN for round-robin read/write arbitration (default: read has priority).
module mna_flit_boxer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    output logic [36:0] noc_data,
    output logic        noc_valid,
    input  logic        noc_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] FLIT_HDR = 2'b10;
    localparam logic [1:0] FLIT_PAY = 2'b01;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_read;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;
    logic        w_grant_rd;
    logic        w_grant_wr;
    logic        w_rready;
    logic        w_bready;
    logic        w_accept;

`ifdef MNA_BOXER_RR_ARB_EN
    // 1 = last accepted response was a read; resets to "last was write" so a read wins first.
    logic r_last_rd;

    // Round-robin grant: on a tie the source that was not granted last time wins.
    always_comb begin
        w_grant_rd = rvalid;
        w_grant_wr = bvalid;
        if (rvalid && bvalid) begin
            w_grant_rd = ~r_last_rd;
            w_grant_wr = r_last_rd;
        end
    end

    // Remember which source was granted on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_rd <= 1'b0;
        end else if (w_accept) begin
            r_last_rd <= w_grant_rd;
        end
    end
`else
    // Fixed priority: a pending read always beats a pending write.
    assign w_grant_rd = rvalid;
    assign w_grant_wr = bvalid & ~rvalid;
`endif

    // Ready is only offered in IDLE and never while reset is asserted.
    assign w_rready = (r_state == ST_IDLE) && w_grant_rd && !rst;
    assign w_bready = (r_state == ST_IDLE) && w_grant_wr && !rst;
    assign w_accept = w_rready | w_bready;
    assign rready   = w_rready;
    assign bready   = w_bready;

    // State register; reset abandons any in-flight flit immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and flit outputs; flit content comes only from holding registers so it is stable under backpressure.
    always_comb begin
        w_next    = r_state;
        noc_valid = 1'b0;
        noc_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_HDR;
                end
            end
            ST_HDR: begin
                noc_valid = 1'b1;
                noc_data  = {FLIT_HDR, 32'd0, r_resp, r_is_read};
                if (noc_ready) begin
                    w_next = r_is_read ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                noc_valid = 1'b1;
                noc_data  = {FLIT_PAY, 3'd0, r_rdata};
                if (noc_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Capture the granted response; held registers only change on an IDLE handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_read <= 1'b0;
            r_resp    <= 2'b00;
            r_rdata   <= 32'd0;
        end else if (w_accept) begin
            r_is_read <= w_grant_rd;
            r_resp    <= w_grant_rd ? rresp : bresp;
            r_rdata   <= w_grant_rd ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mna_flit_boxer.sv
module tb_mna_flit_boxer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rready;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bready;
    logic [36:0] noc_data;
    logic        noc_valid;
    logic        noc_ready = 1'b0;

    mna_flit_boxer dut (
        .clk       (clk),
        .rst       (rst),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rready    (rready),
        .bvalid    (bvalid),
        .bresp     (bresp),
        .bready    (bready),
        .noc_data  (noc_data),
        .noc_valid (noc_valid),
        .noc_ready (noc_ready)
    );

    always #5 clk = ~clk;

    logic [36:0] exp_q[$];
    logic        gq[$];
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    int          rrdy_cnt = 0;
    int          brdy_cnt = 0;
    bit          prev_hold = 1'b0;
    bit          prev_acc = 1'b0;
    logic [36:0] prev_data = '0;

    function automatic logic [36:0] hdr(input logic rd, input logic [1:0] rsp);
        return {2'b10, 32'd0, rsp, rd};
    endfunction

    function automatic logic [36:0] pay(input logic [31:0] d);
        return {2'b01, 3'd0, d};
    endfunction

    task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor, run at the falling edge.
    task automatic mon();
        if (rst) begin
            prev_hold = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            chk("ready_exclusive", {36'd0, rready & bready}, 37'd0);
            if (prev_acc) chk("hdr_latency", {36'd0, noc_valid}, 37'd1);
            if (prev_hold) begin
                chk("hold_valid", {36'd0, noc_valid}, 37'd1);
                chk("hold_data", noc_data, prev_data);
            end
            if (!noc_valid) chk("idle_data", noc_data, 37'd0);
            if (noc_valid && noc_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_flit observed=%h expected=none", noc_data);
                end
                if (exp_q.size() != 0) chk("flit", noc_data, exp_q.pop_front());
            end
            prev_acc = 1'b0;
            if (rvalid && rready) begin
                exp_q.push_back(hdr(1'b1, rresp));
                exp_q.push_back(pay(rdata));
                gq.push_back(1'b1);
                acc_cnt++;
                rrdy_cnt++;
                prev_acc = 1'b1;
            end
            if (bvalid && bready) begin
                exp_q.push_back(hdr(1'b0, bresp));
                gq.push_back(1'b0);
                acc_cnt++;
                brdy_cnt++;
                prev_acc = 1'b1;
            end
            prev_hold = noc_valid && !noc_ready;
            prev_data = noc_data;
        end
    endtask

    // One clock: sample at negedge, return 1 time unit after the next posedge.
    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int n);
        int start;
        start = acc_cnt;
        for (int i = 0; i < 60 && acc_cnt < start + n; i++) cyc();
        total++;
        assert (acc_cnt >= start + n) else begin
            bad++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", acc_cnt - start, n);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || noc_valid); i++) cyc();
        chk("drain_empty", 37'(exp_q.size()), 37'd0);
        chk("drain_idle", {36'd0, noc_valid}, 37'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", {36'd0, noc_valid}, 37'd0);
        chk("rst_data", noc_data, 37'd0);
        chk("rst_rready", {36'd0, rready}, 37'd0);
        chk("rst_bready", {36'd0, bready}, 37'd0);
        exp_q.delete();
        prev_hold = 1'b0;
        prev_acc  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic exp_grant[4];

    initial begin
        // Reset state, with both sources requesting: ready must stay low under reset.
        rvalid = 1'b1;
        bvalid = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        rvalid = 1'b0;
        bvalid = 1'b0;
        cyc();

        // Single read, noc_ready high.
        noc_ready = 1'b1;
        rdata = 32'hDEADBEEF;
        rresp = 2'b00;
        rrdy_cnt = 0;
        rvalid = 1'b1;
        wait_accept(1);
        rvalid = 1'b0;
        chk("rd_hdr", noc_data, 37'h10_0000_0001);
        cyc();
        chk("rd_pay", noc_data, 37'h08_DEADBEEF);
        cyc();
        chk("rd_done", {36'd0, noc_valid}, 37'd0);
        chk("rd_rready_cycles", 37'(rrdy_cnt), 37'd1);
        drain();

        // Single write.
        brdy_cnt = 0;
        bresp = 2'b10;
        bvalid = 1'b1;
        wait_accept(1);
        bvalid = 1'b0;
        chk("wr_hdr", noc_data, 37'h10_0000_0004);
        cyc();
        chk("wr_no_payload", {36'd0, noc_valid}, 37'd0);
        chk("wr_bready_cycles", 37'(brdy_cnt), 37'd1);
        drain();

        // Peak throughput: 3 cycles per read, 2 per write.
        begin
            int start;
            rdata = 32'h0BADF00D;
            rresp = 2'b01;
            start = acc_cnt;
            rvalid = 1'b1;
            for (int i = 0; i < 9; i++) cyc();
            rvalid = 1'b0;
            chk("rd_throughput", 37'(acc_cnt - start), 37'd3);
            drain();
            bresp = 2'b11;
            start = acc_cnt;
            bvalid = 1'b1;
            for (int i = 0; i < 8; i++) cyc();
            bvalid = 1'b0;
            chk("wr_throughput", 37'(acc_cnt - start), 37'd4);
            drain();
        end

        // Backpressure in HDR (5) and DATA (3), with a new read waiting the whole time.
        noc_ready = 1'b0;
        rdata = 32'hA5A51234;
        rresp = 2'b01;
        rvalid = 1'b1;
        wait_accept(1);
        rdata = 32'h11112222;
        rresp = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hdr_stall", {36'd0, rready}, 37'd0);
            cyc();
        end
        chk("bp_hdr_data", noc_data, hdr(1'b1, 2'b01));
        noc_ready = 1'b1;
        cyc();
        noc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_data_stall", {36'd0, rready}, 37'd0);
            cyc();
        end
        chk("bp_pay_data", noc_data, pay(32'hA5A51234));
        noc_ready = 1'b1;
        cyc();
        wait_accept(1);
        rvalid = 1'b0;
        drain();

        // Simultaneous read and write for 4 accepts, starting from reset arbitration state.
        do_reset();
        noc_ready = 1'b1;
        gq.delete();
        rdata = 32'hCAFE0000;
        rresp = 2'b11;
        bresp = 2'b01;
        rvalid = 1'b1;
        bvalid = 1'b1;
        wait_accept(4);
        rvalid = 1'b0;
        bvalid = 1'b0;
        drain();
`ifdef MNA_BOXER_RR_ARB_EN
        exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = (k < gq.size()) ? gq[k] : 1'bx;
            chk($sformatf("grant_%0d", k), {36'd0, g}, {36'd0, exp_grant[k]});
        end

        // Reset while stalled in DATA: flit drops at once, no payload afterwards.
        rdata = 32'h12345678;
        rresp = 2'b00;
        rvalid = 1'b1;
        wait_accept(1);
        rvalid = 1'b0;
        cyc();
        noc_ready = 1'b0;
        cyc();
        chk("rst_mid_pay", noc_data, pay(32'h12345678));
        do_reset();
        noc_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("post_rst_idle", {36'd0, noc_valid}, 37'd0);
        chk("post_rst_empty", 37'(exp_q.size()), 37'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
